// File: rtl/sram_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_share_pkg
// Shared types and helpers for the SRAM sharing arbiter.
//   state_e   : sequencer states (IDLE, ISSUE, WAIT_RD, RESP)
//   DEF_AW/DW : default address / data widths
//   rr_pick() : round-robin priority search over a request vector, starting
//               at a pointer; returns the winner index and a found bit.
// -----------------------------------------------------------------------------
package sram_share_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // rr_pick works on a fixed maximum width so one function serves every N;
  // callers zero-extend their request vector and truncate the result index.
  localparam int RR_MAX_N = 64;
  localparam int RR_IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[0 +: n], scanning ptr, ptr+1, ... wrapping at n.
  // ptr must be below n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t            res;
    int                  cand;
    logic [RR_IDX_W-1:0] cand_idx;
    res = '0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= n) begin
        cand = cand - n;
      end
      cand_idx = RR_IDX_W'(cand);
      if ((k < n) && !res.found && valid[cand_idx]) begin
        res.found = 1'b1;
        res.idx   = cand_idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_share_arb_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority search.
//   valid_i [N-1:0]  : request vector
//   ptr_i   [IW-1:0] : highest-priority index for this pick (must be < N)
//   found_o          : at least one request present
//   idx_o   [IW-1:0] : winning index (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_picker
  import sram_share_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick(RR_MAX_N'(valid_i), RR_IDX_W'(ptr_i), N);
    found_o = pick.found;
    idx_o   = IW'(pick.idx);
  end

endmodule

// File: rtl/sram_share_arb.sv
// -----------------------------------------------------------------------------
// sram_share_arb
// Round-robin arbiter / sequencer sharing one SRAM port between N requesters.
// Each accepted request is relocated by its requester's base address, issued
// to the SRAM, and its completion (plus read data) is returned to the owner.
// Only one transaction is ever outstanding.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start_addr [N][AW]         : per-requester base address, sampled at accept
//   req_valid/req_ready [N]    : per-requester request handshake
//   req_we/req_addr/req_wdata  : per-requester request payload
//   rsp_valid [N], rsp_rdata   : one-cycle completion pulse to the owner
//   mem_valid/mem_ready        : SRAM request handshake
//   mem_we/mem_addr/mem_wdata  : SRAM request payload (absolute address)
//   mem_rvalid/mem_rdata       : SRAM read return
//   busy                       : sequencer not in IDLE
//   gnt_idx                    : current / last owner
// -----------------------------------------------------------------------------
module sram_share_arb
  import sram_share_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0][AW-1:0] start_addr,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N-1:0]         req_we,
  input  logic [N-1:0][AW-1:0] req_addr,
  input  logic [N-1:0][DW-1:0] req_wdata,
  output logic [N-1:0]         rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic [IW-1:0]        gnt_idx
);

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          accept;

  rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_rr_picker (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign accept = (state_q == IDLE) && pick_found;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = ISSUE;
      ISSUE:   if (mem_ready)  state_d = mem_we_q ? RESP : WAIT_RD;
      WAIT_RD: if (mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mem_valid = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE:    if (pick_found) req_ready[pick_idx] = 1'b1;
      ISSUE:   mem_valid = 1'b1;
      WAIT_RD: ;
      RESP:    rsp_valid[gnt_idx_q] = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      // Relocation wraps naturally at AW bits.
      mem_addr_d  = start_addr[pick_idx] + req_addr[pick_idx];
      mem_we_d    = req_we[pick_idx];
      mem_wdata_d = req_we[pick_idx] ? req_wdata[pick_idx] : '0;
      gnt_idx_d   = pick_idx;
      rr_ptr_d    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
      // Cleared here so a write completes with zero read data.
      rsp_rdata_d = '0;
    end
    if ((state_q == WAIT_RD) && mem_rvalid) begin
      rsp_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_sram_share_arb.sv
// -----------------------------------------------------------------------------
// tb_sram_share_arb
// Self-checking bench for sram_share_arb (N=2): directed table of single
// transactions, fairness and mid-read reset sequences, then a randomized run
// checked against a transaction-level reference model with its own memory.
// -----------------------------------------------------------------------------
module tb_sram_share_arb;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0][AW-1:0] start_addr;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         req_we;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0]         rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 mem_valid;
  logic                 mem_ready;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_rvalid;
  logic [DW-1:0]        mem_rdata;
  logic                 busy;
  logic [IW-1:0]        gnt_idx;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  typedef struct {
    int          who;
    bit          we;
    logic [31:0] start;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          rdy_dly;
    int          rd_dly;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  sram_share_arb #(
    .N  (N),
    .AW (AW),
    .DW (DW),
    .IW (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_addr (start_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .gnt_idx    (gnt_idx)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r    = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_mem_valid"}, mem_valid, 0);
    check({tag, "_mem_we"},    mem_we, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_gnt_idx"},   gnt_idx, 0);
    check({tag, "_req_ready"}, req_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
    check_idle_zero("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_zero("after_reset");
  endtask

  // One isolated transaction with a hand-driven SRAM.
  task automatic run_txn(input int id, input vec_t v);
    int           w;
    logic [N-1:0] oh;
    w  = v.who;
    oh = onehot(w);
    @(negedge clk);
    start_addr[w] = v.start;
    req_valid     = oh;
    req_we[w]     = v.we;
    req_addr[w]   = v.addr;
    req_wdata[w]  = v.wdata;
    #1;
    check("t_req_ready", req_ready, oh);
    check("t_idle_busy", busy, 0);
    @(negedge clk);
    // Scramble the payload and raise every request: the DUT must hold its copy.
    req_valid    = '1;
    req_we[w]    = ~v.we;
    req_addr[w]  = ~v.addr;
    req_wdata[w] = ~v.wdata;
    for (int k = 0; k <= v.rdy_dly; k++) begin
      mem_ready  = (k == v.rdy_dly);
      mem_rvalid = (k < v.rdy_dly);
      mem_rdata  = 32'hBAD0BAD0;
      #1;
      check("t_mem_valid", mem_valid, 1);
      check("t_mem_addr", mem_addr, v.exp_addr);
      check("t_mem_we", mem_we, v.we);
      check("t_mem_wdata", mem_wdata, v.exp_wdata);
      check("t_issue_ready", req_ready, 0);
      check("t_issue_rsp", rsp_valid, 0);
      check("t_busy", busy, 1);
      check("t_gnt", gnt_idx, w);
      @(negedge clk);
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    req_valid  = '0;
    if (!v.we) begin
      for (int k = 0; k <= v.rd_dly; k++) begin
        mem_rvalid = (k == v.rd_dly);
        mem_rdata  = (k == v.rd_dly) ? v.rdata : 32'hBAD0BAD0;
        #1;
        check("t_wait_mem_valid", mem_valid, 0);
        check("t_wait_rsp", rsp_valid, 0);
        check("t_wait_busy", busy, 1);
        @(negedge clk);
      end
      mem_rvalid = 1'b0;
    end
    #1;
    check("t_rsp_valid", rsp_valid, oh);
    check("t_rsp_rdata", rsp_rdata, v.exp_rdata);
    check("t_rsp_mem_valid", mem_valid, 0);
    @(negedge clk);
    #1;
    check("t_rsp_done", rsp_valid, 0);
    check("t_idle_again", busy, 0);
    check("t_gnt_hold", gnt_idx, w);
    $display("txn %0d: req%0d %s addr=%08h rdata=%08h", id, w, v.we ? "WR" : "RD",
             v.exp_addr, v.exp_rdata);
  endtask

  task automatic fairness();
    int q_grants[$];
    int last_cyc;
    int w;
    do_reset();
    @(negedge clk);
    start_addr[0] = 32'h0000_0100;
    start_addr[1] = 32'h0000_0200;
    req_valid     = '1;
    req_we        = '1;
    req_addr[0]   = 32'h4;
    req_addr[1]   = 32'h8;
    req_wdata[0]  = 32'h1111_0000;
    req_wdata[1]  = 32'h2222_0000;
    mem_ready     = 1'b1;
    mem_rvalid    = 1'b0;
    last_cyc      = -1;
    for (int cyc = 0; cyc < 40 && q_grants.size() < 6; cyc++) begin
      #1;
      check("fair_onehot0", $onehot0(req_ready), 1);
      if (req_ready != '0) begin
        w = req_ready[1] ? 1 : 0;
        check("fair_order", w, q_grants.size() % 2);
        if (last_cyc >= 0) check("fair_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        q_grants.push_back(w);
        $display("txn fair %0d: grant req%0d at cycle %0d", q_grants.size(), w, cyc);
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("fair_count", q_grants.size(), 6);
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("fair_drained", busy, 0);
  endtask

  task automatic reset_mid_read();
    @(negedge clk);
    start_addr[0] = 32'h0000_4000;
    req_valid     = 2'b01;
    req_we        = 2'b00;
    req_addr[0]   = 32'h20;
    #1;
    check("mr_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    mem_ready = 1'b1;
    #1;
    check("mr_issue", mem_valid, 1);
    check("mr_addr", mem_addr, 32'h0000_4020);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("mr_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_reset_busy", busy, 0);
    check("mr_reset_rsp", rsp_valid, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    #1;
    check("mr_late_rsp", rsp_valid, 0);
    check("mr_late_busy", busy, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check("mr_after_rsp", rsp_valid, 0);
    check("mr_after_busy", busy, 0);
    check("mr_after_rdata", rsp_rdata, 0);
    req_valid    = '1;
    req_we       = '1;
    req_addr[1]  = 32'h4;
    req_wdata[0] = 32'h0BAD_F00D;
    #1;
    check("mr_regrant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    mem_ready = 1'b1;
    #1;
    check("mr_re_addr", mem_addr, 32'h0000_4020);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("mr_re_rsp", rsp_valid, 2'b01);
    @(negedge clk);
    $display("txn reset-mid-read: regrant to req0");
  endtask

  // Randomized run; the reference tracks the single outstanding transaction
  // as a record plus two milestones (SRAM accepted, data returned).
  task automatic random_phase();
    bit            have, hs, rsp_now, rd_pend;
    int            ptr, win, idx, rd_wait, n_done;
    int            t_who;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    logic [N-1:0]  exp_ready, drop;
    have = 0; hs = 0; rsp_now = 0; rd_pend = 0;
    ptr = 0; rd_wait = 0; n_done = 0;
    t_who = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    drop = '0;
    do_reset();
    start_addr[0] = $urandom;
    start_addr[1] = 32'hFFFF_FFF0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~drop;
      drop      = '0;
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] && $urandom_range(0, 2) != 0) begin
          req_valid[r] = 1'b1;
          req_we[r]    = 1'($urandom_range(0, 1));
          req_addr[r]  = 32'($urandom_range(0, 7)) * 4;
          req_wdata[r] = $urandom;
        end
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      if (rd_pend && rd_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = t_rdata;
      end else begin
        if (rd_pend) begin
          mem_rvalid = 1'b0;
          rd_wait--;
        end else begin
          mem_rvalid = ($urandom_range(0, 5) == 0);
        end
        mem_rdata = $urandom;
      end
      #1;
      exp_ready = '0;
      win       = -1;
      if (!have) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (win < 0 && req_valid[idx]) win = idx;
        end
        if (win >= 0) exp_ready = onehot(win);
      end
      check("r_req_ready", req_ready, exp_ready);
      check("r_busy", busy, have);
      if (have) check("r_gnt", gnt_idx, t_who);
      check("r_mem_valid", mem_valid, have && !hs);
      if (have && !hs) begin
        check("r_mem_addr", mem_addr, t_addr);
        check("r_mem_we", mem_we, t_we);
        check("r_mem_wdata", mem_wdata, t_wdata);
      end
      check("r_rsp_valid", rsp_valid, rsp_now ? onehot(t_who) : '0);
      if (rsp_now) check("r_rsp_rdata", rsp_rdata, t_rdata);
      @(posedge clk);
      if (!have) begin
        if (win >= 0) begin
          have    = 1;
          hs      = 0;
          t_who   = win;
          t_we    = req_we[win];
          t_addr  = start_addr[win] + req_addr[win];
          t_wdata = t_we ? req_wdata[win] : '0;
          ptr     = (win + 1) % N;
          drop    = onehot(win);
        end
      end else if (rsp_now) begin
        have    = 0;
        rsp_now = 0;
        n_done++;
        $display("txn rand %0d: req%0d %s addr=%08h data=%08h", n_done, t_who,
                 t_we ? "WR" : "RD", t_addr, t_we ? t_wdata : t_rdata);
      end else if (!hs) begin
        if (mem_ready) begin
          hs = 1;
          if (t_we) begin
            ref_mem[t_addr] = t_wdata;
            t_rdata         = '0;
            rsp_now         = 1;
          end else begin
            t_rdata = ref_mem.exists(t_addr) ? ref_mem[t_addr] : (t_addr ^ 32'h3C3C_5A5A);
            rd_pend = 1;
            rd_wait = $urandom_range(0, 2);
          end
        end
      end else if (rd_pend && mem_rvalid) begin
        rd_pend = 0;
        rsp_now = 1;
      end
    end
    check("r_progress", n_done > 40, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start_addr = '0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    //          who we    start         addr          wdata         rdata         exp_addr      exp_wdata     exp_rdata    rdy rd
    vecs[0] = '{0, 1'b0, 32'h0123_4567, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0123_4577, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0};
    vecs[1] = '{1, 1'b1, 32'h89AB_CDEF, 32'h7654_3220, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_000F, 32'hA5A5_A5A5, 32'h0000_0000, 0, 0};
    vecs[2] = '{1, 1'b0, 32'h0000_1000, 32'h0000_0FFC, 32'h7777_7777, 32'h1357_9BDF, 32'h0000_1FFC, 32'h0000_0000, 32'h1357_9BDF, 5, 1};
    vecs[3] = '{0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0F0F_0F0F, 32'h0000_0000, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_0000, 2, 0};
    vecs[4] = '{0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1111_2222, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0000_0000, 32'hCAFE_F00D, 0, 3};

    do_reset();
    for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);
    fairness();
    reset_mid_read();
    random_phase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
